// File: rtl/axi_stream_packet_arbiter.sv
// Packet-granular round-robin arbiter feeding the 32-bit s-side of the upconverter chain.
// Optional stall timeout with a forced-termination beat is enabled by defining ARB_TIMEOUT_EN.
module axi_stream_packet_arbiter #(
  parameter int NSRC           = 4,
  parameter int IDX_W          = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NSRC*32-1:0]  sAxiStreamTdata,
  input  logic [NSRC-1:0]     sAxiStreamTlast,
  input  logic [NSRC-1:0]     sAxiStreamTvalid,
  output logic [NSRC-1:0]     sAxiStreamTready,
  output logic [31:0]         mAxiStreamTdata,
  output logic                mAxiStreamTlast,
  output logic                mAxiStreamTvalid,
  input  logic                mAxiStreamTready,
  output logic [IDX_W-1:0]    grantIndex,
  output logic                busy,
  output logic                timeoutStrobe
);

`ifdef ARB_TIMEOUT_EN
  typedef enum logic [1:0] {ST_IDLE, ST_PASS, ST_FLUSH} state_t;
`else
  typedef enum logic [1:0] {ST_IDLE, ST_PASS} state_t;
`endif

  state_t           r_state;
  state_t           w_state_next;
  logic [IDX_W-1:0] r_grant;
  logic [IDX_W-1:0] r_last_grant;
  logic [IDX_W-1:0] w_sel;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;
  logic             w_g_valid;
  logic             w_g_last;
  logic [31:0]      w_g_data;

  // Scan downwards so the lowest offset from the last grant overwrites last and wins.
  always_comb begin
    w_any = 1'b0;
    w_sel = r_last_grant;
    w_idx = r_last_grant;
    for (int k = NSRC; k >= 1; k--) begin
      w_idx = IDX_W'((int'(r_last_grant) + k) % NSRC);
      if (sAxiStreamTvalid[w_idx]) begin
        w_any = 1'b1;
        w_sel = w_idx;
      end
    end
  end

  assign w_g_valid  = sAxiStreamTvalid[r_grant];
  assign w_g_last   = sAxiStreamTlast[r_grant];
  assign w_g_data   = sAxiStreamTdata[32*r_grant +: 32];
  assign grantIndex = r_grant;
  assign busy       = (r_state != ST_IDLE);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_strobe;
  logic             w_stall_expired;

  assign w_stall_expired = !w_g_valid && (r_stall_cnt == CNT_LIMIT);
  assign timeoutStrobe   = r_timeout_strobe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt      <= '0;
      r_timeout_strobe <= 1'b0;
    end else begin
      r_timeout_strobe <= (r_state == ST_FLUSH) && mAxiStreamTready;
      if (r_state != ST_PASS || w_g_valid) begin
        r_stall_cnt <= '0;
      end else if (r_stall_cnt != CNT_LIMIT) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end
`else
  assign timeoutStrobe = 1'b0;
`endif

  always_comb begin
    w_state_next     = r_state;
    mAxiStreamTvalid = 1'b0;
    mAxiStreamTlast  = 1'b0;
    mAxiStreamTdata  = '0;
    sAxiStreamTready = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) w_state_next = ST_PASS;
      end
      ST_PASS: begin
        mAxiStreamTvalid = w_g_valid;
        mAxiStreamTlast  = w_g_last;
        mAxiStreamTdata  = w_g_data;
        sAxiStreamTready = NSRC'(mAxiStreamTready) << r_grant;
        if (w_g_valid && mAxiStreamTready && w_g_last) begin
          w_state_next = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
        end else if (w_stall_expired) begin
          w_state_next = ST_FLUSH;
`endif
        end
      end
`ifdef ARB_TIMEOUT_EN
      ST_FLUSH: begin
        mAxiStreamTvalid = 1'b1;
        mAxiStreamTlast  = 1'b1;
        if (mAxiStreamTready) w_state_next = ST_IDLE;
      end
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NSRC - 1);
    end else begin
      r_state <= w_state_next;
      if (r_state == ST_IDLE && w_any) begin
        r_grant      <= w_sel;
        r_last_grant <= w_sel;
      end
    end
  end

endmodule
